// File: rtl/twd_trans_pool_ipa.sv
// twd_trans_pool_ipa: multi-port pool of 2D transaction descriptor slots.
// Round-robin slot allocation, per-core writes, per-port read/peek/release.
`default_nettype none

module twd_trans_pool_ipa #(
  parameter int NB_CORES    = 4,
  parameter int NB_RD_PORTS = 2,
  parameter int ENTRY_WIDTH = 32,
  parameter int DEPTH       = 8,
  parameter int ADD_WIDTH   = $clog2(DEPTH),
  parameter int CNT_WIDTH   = $clog2(DEPTH + 1)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      clear_i,
  input  logic [NB_CORES-1:0]                       alloc_req_i,
  output logic [NB_CORES-1:0]                       alloc_gnt_o,
  output logic [NB_CORES-1:0][ADD_WIDTH-1:0]        alloc_add_o,
  input  logic [NB_CORES-1:0]                       wr_req_i,
  input  logic [NB_CORES-1:0][ADD_WIDTH-1:0]        wr_add_i,
  input  logic [NB_CORES-1:0][ENTRY_WIDTH-1:0]      wr_dat_i,
  input  logic [NB_RD_PORTS-1:0]                    rd_req_i,
  input  logic [NB_RD_PORTS-1:0]                    rd_rel_i,
  input  logic [NB_RD_PORTS-1:0][ADD_WIDTH-1:0]     rd_add_i,
  output logic [NB_RD_PORTS-1:0][ENTRY_WIDTH-1:0]   rd_dat_o,
  output logic [NB_RD_PORTS-1:0]                    rd_vld_o,
  output logic [CNT_WIDTH-1:0]                      cnt_o,
  output logic                                      full_o,
  output logic                                      empty_o,
  output logic [1:0]                                err_o
);

  localparam int RR_WIDTH = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;

  logic [DEPTH-1:0]                  busy_q, busy_d;
  logic [DEPTH-1:0]                  wvld_q, wvld_d;
  logic [DEPTH-1:0]                  rel_mask;
  logic [DEPTH-1:0][ENTRY_WIDTH-1:0] data_q, data_d;
  logic [RR_WIDTH-1:0]               rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0]              cnt_q, cnt_d;
  logic [1:0]                        err_q, err_d;
  logic [ADD_WIDTH-1:0]              free_ptr;
  logic [RR_WIDTH-1:0]               gnt_idx;
  logic                              gnt_any;
  logic [CNT_WIDTH-1:0]              rel_cnt;
  int                                arb_c;

  // Lowest free slot, taken from registered busy only (no release bypass).
  always_comb begin
    free_ptr = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_ptr = ADD_WIDTH'(i);
    end
  end

  // Scan downward so the last hit is the first requester at or after rr_ptr.
  always_comb begin
    alloc_gnt_o = '0;
    gnt_any     = 1'b0;
    gnt_idx     = '0;
    arb_c       = 0;
    if (rst_ni && !clear_i && !full_o) begin
      for (int i = NB_CORES - 1; i >= 0; i--) begin
        arb_c = (int'(rr_ptr_q) + i) % NB_CORES;
        if (alloc_req_i[arb_c]) begin
          gnt_any = 1'b1;
          gnt_idx = RR_WIDTH'(arb_c);
        end
      end
      if (gnt_any) alloc_gnt_o[gnt_idx] = 1'b1;
    end
  end

  assign alloc_add_o = {NB_CORES{free_ptr}};

  always_comb begin
    rd_dat_o = '0;
    rd_vld_o = '0;
    for (int p = 0; p < NB_RD_PORTS; p++) begin
      if (int'(rd_add_i[p]) < DEPTH) begin
        rd_dat_o[p] = data_q[rd_add_i[p]];
        rd_vld_o[p] = busy_q[rd_add_i[p]] & wvld_q[rd_add_i[p]];
      end
    end
  end

  always_comb begin
    busy_d   = busy_q;
    wvld_d   = wvld_q;
    data_d   = data_q;
    rr_ptr_d = rr_ptr_q;
    err_d    = err_q;
    rel_mask = '0;
    rel_cnt  = '0;

    // Ascending core order: the highest core index writing a slot wins.
    for (int c = 0; c < NB_CORES; c++) begin
      if (wr_req_i[c]) begin
        if (int'(wr_add_i[c]) < DEPTH && busy_q[wr_add_i[c]]) begin
          data_d[wr_add_i[c]] = wr_dat_i[c];
          wvld_d[wr_add_i[c]] = 1'b1;
        end else begin
          err_d[0] = 1'b1;
        end
      end
    end

    for (int p = 0; p < NB_RD_PORTS; p++) begin
      if (rd_req_i[p] && rd_rel_i[p]) begin
        if (int'(rd_add_i[p]) < DEPTH && busy_q[rd_add_i[p]]) rel_mask[rd_add_i[p]] = 1'b1;
        else err_d[1] = 1'b1;
      end
    end

    // Count distinct released slots so a double release only frees once.
    for (int i = 0; i < DEPTH; i++) begin
      if (rel_mask[i]) rel_cnt = rel_cnt + CNT_WIDTH'(1);
    end
    busy_d = busy_d & ~rel_mask;
    wvld_d = wvld_d & ~rel_mask;

    if (gnt_any) begin
      busy_d[free_ptr] = 1'b1;
      wvld_d[free_ptr] = 1'b0;
      rr_ptr_d = (gnt_idx == RR_WIDTH'(NB_CORES - 1)) ? '0 : gnt_idx + RR_WIDTH'(1);
    end
    cnt_d = cnt_q + CNT_WIDTH'(gnt_any) - rel_cnt;

    if (clear_i) begin
      busy_d   = '0;
      wvld_d   = '0;
      data_d   = data_q;
      err_d    = '0;
      rr_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q   <= '0;
      wvld_q   <= '0;
      data_q   <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      wvld_q   <= wvld_d;
      data_q   <= data_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign full_o  = (cnt_q == CNT_WIDTH'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign err_o   = err_q;

endmodule

`default_nettype wire
